// File: rtl/uart_rx_fsm.sv
// 8N1 UART receive controller: synchronises rx, frames the byte using the
// external bit-timing counter's mid-bit pulse, and holds it on a valid/ready register.
module uart_rx_fsm #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 half_bit_flag,
  output logic                 cnt_reset,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  // Output handshake: a byte transfers on every clk where rx_valid & rx_ready;
  // rx_data is stable whenever rx_valid is high and is never withdrawn unaccepted.

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_d, start_edge;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [IDX_W-1:0]       bit_idx;
  logic                   byte_done, stop_err;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_d & ~rx_s;
  assign cnt_reset  = (state == IDLE);
  assign rx_busy    = (state != IDLE);

  // Flops preset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d   <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    case (state)
      IDLE:  if (start_edge) state_n = START;
      START: if (half_bit_flag) state_n = rx_s ? IDLE : DATA;
      DATA:  if (half_bit_flag && (bit_idx == LAST_IDX)) state_n = STOP;
      STOP: begin
        if (half_bit_flag) begin
          state_n   = IDLE;
          byte_done = rx_s;
          stop_err  = ~rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else if (half_bit_flag) begin
      if (state == START) bit_idx <= '0;
      if (state == DATA) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        bit_idx   <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
      end
    end
  end

  // A completing byte wins over a same-cycle accept, so rx_valid stays high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_err;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
